// File: rtl/sprite_line_scheduler_if.sv
// Control and list-read bundle between sprite_line_scheduler and its client.
// The master side (frame_displayer and line timing) drives line_start, line_y
// and rd_idx. The slave side (the scheduler) returns status and list entries.
interface sprite_line_scheduler_if #(
  parameter int COORD_W = 10,
  parameter int YOFF_W  = 6
);
  logic               line_start;
  logic [COORD_W-1:0] line_y;
  logic               busy;
  logic               done;
  logic [3:0]         active_count;
  logic               overflow;
  logic [2:0]         rd_idx;
  logic [3:0]         rd_slot;
  logic [COORD_W-1:0] rd_x;
  logic [YOFF_W-1:0]  rd_y_off;
  logic [2:0]         rd_state;

  modport master (
    output line_start, line_y, rd_idx,
    input  busy, done, active_count, overflow,
    input  rd_slot, rd_x, rd_y_off, rd_state
  );

  modport slave (
    input  line_start, line_y, rd_idx,
    output busy, done, active_count, overflow,
    output rd_slot, rd_x, rd_y_off, rd_state
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. During horizontal blanking it walks every
// sprite slot, one per cycle, and collects up to MAX_ACTIVE slots that cover
// the requested line. The list is then published to a double-buffered set of
// registers, which frame_displayer reads through a combinational indexed port.
// Optional macro SPRITE_PRIORITY_ROTATE_EN: the scan start slot rotates by one
// after every overflowing line, so dropped sprites rotate across lines.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 10,
  parameter int MAX_ACTIVE  = 4,
  parameter int SPRITE_H    = 64,
  parameter int COORD_W     = 10
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  input  logic [NUM_SPRITES*3-1:0]       spr_state,
  sprite_line_scheduler_if.slave         bus
);

  localparam int YOFF_W = $clog2(SPRITE_H);
  localparam logic [3:0]       LAST_SLOT = 4'(NUM_SPRITES - 1);
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_ACTIVE);
  localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W + 1)'(SPRITE_H);

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  typedef struct packed {
    logic [3:0]         slot;
    logic [COORD_W-1:0] x;
    logic [YOFF_W-1:0]  yoff;
    logic [2:0]         state;
  } entry_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] ly_q, ly_d;
  logic [3:0]         scan_cnt_q, scan_cnt_d;
  logic [3:0]         slot_q, slot_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [3:0]         pcnt_q, pcnt_d;
  logic               wov_q, wov_d;
  logic               pov_q, pov_d;
  logic               done_q, done_d;
  entry_t             work_q [MAX_ACTIVE];
  entry_t             work_d [MAX_ACTIVE];
  entry_t             pub_q  [MAX_ACTIVE];
  entry_t             pub_d  [MAX_ACTIVE];
  logic [3:0]         start_slot;

`ifdef SPRITE_PRIORITY_ROTATE_EN
  logic [3:0]         rot_ptr_q, rot_ptr_d;
  assign start_slot = rot_ptr_q;
`else
  assign start_slot = '0;
`endif

  // Fields of the slot currently being scanned
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [2:0]         sel_st;
  logic [COORD_W:0]   y_diff;
  logic               hit;
  entry_t             new_entry;

  // Select the current slot's coordinates and state from the packed inputs
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_st = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (slot_q == 4'(i)) begin
        sel_x  = spr_x[i*COORD_W +: COORD_W];
        sel_y  = spr_y[i*COORD_W +: COORD_W];
        sel_st = spr_state[i*3 +: 3];
      end
    end
  end

  // Hit test: active slot whose vertical span covers the latched line, no wrap
  always_comb begin
    y_diff          = {1'b0, ly_q} - {1'b0, sel_y};
    hit             = (sel_st != 3'd0) && (ly_q >= sel_y) && (y_diff < SPR_H_EXT);
    new_entry.slot  = slot_q;
    new_entry.x     = sel_x;
    new_entry.yoff  = y_diff[YOFF_W-1:0];
    new_entry.state = sel_st;
  end

  // Next-state logic for the scan FSM, working list and published list
  always_comb begin
    state_d    = state_q;
    ly_d       = ly_q;
    scan_cnt_d = scan_cnt_q;
    slot_d     = slot_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    wov_d      = wov_q;
    pov_d      = pov_q;
    done_d     = 1'b0;
    work_d     = work_q;
    pub_d      = pub_q;
`ifdef SPRITE_PRIORITY_ROTATE_EN
    rot_ptr_d  = rot_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          ly_d       = bus.line_y;
          wcnt_d     = '0;
          wov_d      = 1'b0;
          scan_cnt_d = '0;
          slot_d     = start_slot;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          if (wcnt_q < MAX_CNT) begin
            for (int unsigned e = 0; e < MAX_ACTIVE; e++) begin
              if (wcnt_q == 4'(e)) work_d[e] = new_entry;
            end
            wcnt_d = wcnt_q + 4'd1;
          end else begin
            wov_d = 1'b1;
          end
        end
        scan_cnt_d = scan_cnt_q + 4'd1;
        slot_d     = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
        if (scan_cnt_q == LAST_SLOT) state_d = PUBLISH;
      end
      PUBLISH: begin
        pub_d   = work_q;
        pcnt_d  = wcnt_q;
        pov_d   = wov_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SPRITE_PRIORITY_ROTATE_EN
        if (wov_q) rot_ptr_d = (rot_ptr_q == LAST_SLOT) ? 4'd0 : rot_ptr_q + 4'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ly_q       <= '0;
      scan_cnt_q <= '0;
      slot_q     <= '0;
      wcnt_q     <= '0;
      pcnt_q     <= '0;
      wov_q      <= 1'b0;
      pov_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned e = 0; e < MAX_ACTIVE; e++) begin
        work_q[e] <= '0;
        pub_q[e]  <= '0;
      end
`ifdef SPRITE_PRIORITY_ROTATE_EN
      rot_ptr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ly_q       <= ly_d;
      scan_cnt_q <= scan_cnt_d;
      slot_q     <= slot_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      wov_q      <= wov_d;
      pov_q      <= pov_d;
      done_q     <= done_d;
      work_q     <= work_d;
      pub_q      <= pub_d;
`ifdef SPRITE_PRIORITY_ROTATE_EN
      rot_ptr_q  <= rot_ptr_d;
`endif
    end
  end

  // Status outputs. done is registered, so it coincides with the first
  // cycle in which the newly published list is visible.
  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.done         = done_q;
    bus.active_count = pcnt_q;
    bus.overflow     = pov_q;
  end

  // Read port: entries at or beyond the published count read as zero
  always_comb begin
    bus.rd_slot  = '0;
    bus.rd_x     = '0;
    bus.rd_y_off = '0;
    bus.rd_state = '0;
    for (int unsigned e = 0; e < MAX_ACTIVE; e++) begin
      if ((bus.rd_idx == 3'(e)) && (4'(e) < pcnt_q)) begin
        bus.rd_slot  = pub_q[e].slot;
        bus.rd_x     = pub_q[e].x;
        bus.rd_y_off = pub_q[e].yoff;
        bus.rd_state = pub_q[e].state;
      end
    end
  end

endmodule
